// File: rtl/tdc_pkg.sv
// Shared TDC definitions: sizing helpers, default widths, timestamp layout, popcount.
// Pure declarations: no latency, no flow control.
package tdc_pkg;

  localparam int DEF_NCARRY4  = 16;
  localparam int DEF_COARSE_W = 16;
  localparam int MAX_TAPS     = 256;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  localparam int DEF_FINE_W = clog2(4 * DEF_NCARRY4 + 1);

  // Field order of a timestamp record; the top rebuilds it at its own widths.
  typedef struct packed {
    logic [3:0]              channel;
    logic [DEF_COARSE_W-1:0] coarse;
    logic [DEF_FINE_W-1:0]   fine;
    logic                    sat;
  } ts_t;

  // Counting ones instead of locating the first zero makes bubbles harmless.
  function automatic int unsigned popcount(input logic [MAX_TAPS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_TAPS; i++) n = n + {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/carry_chain_tap.sv
// One channel's cascaded CARRY4 delay line plus the two metastability sampling stages.
// Latency 2 clk from tap to s2; free-running, no flow control.
module carry_chain_tap #(
  parameter  int NCARRY4 = 16,
  localparam int TAPS    = 4 * NCARRY4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hit,
  output logic [TAPS-1:0] s2
);

  // Every cell propagates (S=1, DI=0) so each CO output is a delayed copy of hit.
  localparam logic [3:0] CELL_S  = 4'hF;
  localparam logic [3:0] CELL_DI = 4'h0;

  logic [TAPS-1:0] co;
  logic [TAPS-1:0] taps;
  logic [TAPS-1:0] s1;
  logic            carry;

  always_comb begin
    carry = hit;
    co    = '0;
    for (int j = 0; j < TAPS; j++) begin
      carry = CELL_S[j % 4] ? carry : CELL_DI[j % 4];
      co[j] = carry;
    end
  end

  assign taps = co;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= taps;
      s2 <= s1;
    end
  end

endmodule

// File: rtl/tdc_multichannel_fine_stage.sv
// N-channel TDC fine stage: edge detect, popcount fine code, coarse tag, round-robin merge.
// Hit-to-out_valid 3 clk after first tap sample; one-deep holding per channel drops (ovf) under backpressure.
module tdc_multichannel_fine_stage
  import tdc_pkg::*;
#(
  parameter  int NCHANNELS = 4,
  parameter  int NCARRY4   = DEF_NCARRY4,
  parameter  int COARSE_W  = DEF_COARSE_W,
  localparam int TAPS      = 4 * NCARRY4,
  localparam int FINE_W    = clog2(TAPS + 1),
  localparam int CH_W      = (NCHANNELS > 1) ? clog2(NCHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCHANNELS-1:0] hit,
  input  logic                 enable,
  input  logic                 clr_ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH_W-1:0]      out_channel,
  output logic [COARSE_W-1:0]  out_coarse,
  output logic [FINE_W-1:0]    out_fine,
  output logic                 out_sat,
  output logic [NCHANNELS-1:0] ovf
);

  typedef struct packed {
    logic [CH_W-1:0]     channel;
    logic [COARSE_W-1:0] coarse;
    logic [FINE_W-1:0]   fine;
    logic                sat;
  } rec_t;

  logic [COARSE_W-1:0]  coarse_cnt;
  logic [COARSE_W-1:0]  c1;
  logic [COARSE_W-1:0]  c2;
  logic [TAPS-1:0]      s2 [NCHANNELS];
  logic [FINE_W-1:0]    fine_now [NCHANNELS];
  logic [NCHANNELS-1:0] sat_now;
  logic [NCHANNELS-1:0] s2_tap0;
  logic [NCHANNELS-1:0] s3_tap0;
  logic [NCHANNELS-1:0] det;
  logic [NCHANNELS-1:0] drop;
  logic [NCHANNELS-1:0] pend;
  logic [NCHANNELS-1:0] gnt_vec;
  rec_t                 hold [NCHANNELS];
  rec_t                 out_q;
  logic [CH_W-1:0]      rr;
  logic [CH_W-1:0]      gnt_idx;
  logic [CH_W-1:0]      next_rr;
  logic                 gnt_any;
  logic                 can_load;
  int                   arb_idx;

  for (genvar i = 0; i < NCHANNELS; i++) begin : g_ch
    carry_chain_tap #(.NCARRY4(NCARRY4)) u_chain (
      .clk   (clk),
      .rst_n (rst_n),
      .hit   (hit[i]),
      .s2    (s2[i])
    );
    assign s2_tap0[i]  = s2[i][0];
    assign fine_now[i] = FINE_W'(popcount(MAX_TAPS'(s2[i])));
    assign sat_now[i]  = (fine_now[i] == FINE_W'(TAPS));
  end

  assign det      = {NCHANNELS{enable}} & s2_tap0 & ~s3_tap0;
  assign can_load = ~out_valid | out_ready;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_vec = '0;
    arb_idx = 0;
    for (int k = 0; k < NCHANNELS; k++) begin
      arb_idx = (int'(rr) + k) % NCHANNELS;
      if (can_load && !gnt_any && pend[arb_idx]) begin
        gnt_any          = 1'b1;
        gnt_idx          = CH_W'(arb_idx);
        gnt_vec[arb_idx] = 1'b1;
      end
    end
  end

  assign next_rr = (gnt_idx == CH_W'(NCHANNELS - 1)) ? '0 : gnt_idx + 1'b1;

  // A detection into an occupied entry is dropped unless that entry leaves this cycle.
  assign drop = det & pend & ~gnt_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_tap0 <= '0;
      pend    <= '0;
      ovf     <= '0;
      for (int i = 0; i < NCHANNELS; i++) hold[i] <= '0;
    end else begin
      s3_tap0 <= s2_tap0;
      for (int i = 0; i < NCHANNELS; i++) begin
        if (drop[i]) begin
          ovf[i] <= 1'b1;
        end else if (clr_ovf) begin
          ovf[i] <= 1'b0;
        end
        if (det[i] && !drop[i]) begin
          pend[i] <= 1'b1;
          hold[i] <= '{channel: CH_W'(i), coarse: c2, fine: fine_now[i], sat: sat_now[i]};
        end else if (gnt_vec[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // c1/c2 track s1/s2 so a detection carries the count seen when its tap was first sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coarse_cnt <= '0;
      c1         <= '0;
      c2         <= '0;
      rr         <= '0;
      out_valid  <= 1'b0;
      out_q      <= '0;
    end else begin
      coarse_cnt <= coarse_cnt + 1'b1;
      c1         <= coarse_cnt;
      c2         <= c1;
      if (can_load) begin
        out_valid <= gnt_any;
        if (gnt_any) begin
          out_q <= hold[gnt_idx];
          rr    <= next_rr;
        end
      end
    end
  end

  assign out_channel = out_q.channel;
  assign out_coarse  = out_q.coarse;
  assign out_fine    = out_q.fine;
  assign out_sat     = out_q.sat;

endmodule

// File: tb/tb_tdc_multichannel_fine_stage.sv
// Bench for the TDC fine stage; each chain's taps are driven as a bench-chosen thermometer.
module tb_tdc_multichannel_fine_stage;

  localparam int NCH  = 4;
  localparam int TAPS = 64;
  localparam int CW   = 16;
  localparam int FW   = 7;
  localparam int CHW  = 2;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [CW-1:0]  coarse;
    logic [FW-1:0]  fine;
    logic           sat;
  } rec_t;

  typedef struct {
    int   ch;
    int   len;
    int   bubble;
    int   exp_fine;
    logic exp_sat;
  } vec_t;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic           enable    = 1'b0;
  logic           clr_ovf   = 1'b0;
  logic           out_ready = 1'b0;
  logic [NCH-1:0] hit       = '0;
  logic           out_valid;
  logic [CHW-1:0] out_channel;
  logic [CW-1:0]  out_coarse;
  logic [FW-1:0]  out_fine;
  logic           out_sat;
  logic [NCH-1:0] ovf;

  logic [TAPS-1:0] tap0 = '0;
  logic [TAPS-1:0] tap1 = '0;
  logic [TAPS-1:0] tap2 = '0;
  logic [TAPS-1:0] tap3 = '0;

  logic [CW-1:0] model_coarse;
  rec_t          sb[$];
  rec_t          mon_got;
  rec_t          mon_exp;
  int            checks   = 0;
  int            errors   = 0;
  int            rx_count = 0;

  tdc_multichannel_fine_stage #(.NCHANNELS(NCH), .NCARRY4(16), .COARSE_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hit         (hit),
    .enable      (enable),
    .clr_ovf     (clr_ovf),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_channel (out_channel),
    .out_coarse  (out_coarse),
    .out_fine    (out_fine),
    .out_sat     (out_sat),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_coarse <= '0;
    else        model_coarse <= model_coarse + 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      mon_got = '{out_channel, out_coarse, out_fine, out_sat};
      rx_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record: got ch=%0d coarse=%0d fine=%0d sat=%0b, required no record",
                 mon_got.ch, mon_got.coarse, mon_got.fine, mon_got.sat);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL record: got ch=%0d coarse=%0d fine=%0d sat=%0b, required ch=%0d coarse=%0d fine=%0d sat=%0b",
                   mon_got.ch, mon_got.coarse, mon_got.fine, mon_got.sat,
                   mon_exp.ch, mon_exp.coarse, mon_exp.fine, mon_exp.sat);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_taps(input int ch, input logic [TAPS-1:0] v);
    case (ch)
      0:       tap0 = v;
      1:       tap1 = v;
      2:       tap2 = v;
      default: tap3 = v;
    endcase
    hit[ch] = v[0];
  endtask

  function automatic logic [TAPS-1:0] therm(input int len, input int bubble);
    logic [TAPS-1:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v[i] = 1'b1;
    if (bubble >= 0) v[bubble] = 1'b0;
    return v;
  endfunction

  task automatic push(input int ch, input logic [CW-1:0] coarse, input int fine, input logic sat);
    sb.push_back('{CHW'(ch), coarse, FW'(fine), sat});
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s: drain timeout with %0d records outstanding, required 0", name, sb.size());
    end
  endtask

  initial begin
    vec_t       vecs[5];
    int         n;
    int         rx0;
    logic [2:0] tp;

    force dut.g_ch[0].u_chain.taps = tap0;
    force dut.g_ch[1].u_chain.taps = tap1;
    force dut.g_ch[2].u_chain.taps = tap2;
    force dut.g_ch[3].u_chain.taps = tap3;

    vecs[0] = '{0, 20, -1, 20, 1'b0};
    vecs[1] = '{0, 64, -1, 64, 1'b1};
    vecs[2] = '{0, 30, 10, 29, 1'b0};
    vecs[3] = '{2, 1,  -1, 1,  1'b0};
    vecs[4] = '{3, 63, -1, 63, 1'b0};

    #3;
    check("reset_outputs", 64'({out_valid, out_channel, out_coarse, out_fine, out_sat, ovf}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    enable    = 1'b1;
    out_ready = 1'b1;

    // Single hits, one at a time; the first is sampled with coarse=100.
    n = 0;
    while (model_coarse != 16'd100 && n < 200) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      set_taps(vecs[i].ch, therm(vecs[i].len, vecs[i].bubble));
      push(vecs[i].ch, model_coarse, vecs[i].exp_fine, vecs[i].exp_sat);
      n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
      check("latency", 64'(n), 64'(4));
      set_taps(vecs[i].ch, '0);
      wait_drain("table");
      repeat (2) tick();
    end

    // ch1+ch3 together, ch0 one cycle later: ch1, ch3, ch0 back to back.
    set_taps(1, therm(10, -1));
    set_taps(3, therm(40, -1));
    push(1, model_coarse, 10, 1'b0);
    push(3, model_coarse, 40, 1'b0);
    tick();
    set_taps(0, therm(5, -1));
    push(0, model_coarse, 5, 1'b0);
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      tp[k] = out_valid;
      tick();
    end
    check("back_to_back", 64'(tp), 64'(3'b111));
    set_taps(0, '0);
    set_taps(1, '0);
    set_taps(3, '0);
    wait_drain("simultaneous");
    repeat (2) tick();

    // Stalled output: ch0 occupies it, ch2 first hit waits, second ch2 hit drops.
    out_ready = 1'b0;
    set_taps(0, therm(8, -1));
    push(0, model_coarse, 8, 1'b0);
    repeat (2) tick();
    set_taps(0, '0);
    tick();
    set_taps(2, therm(16, -1));
    push(2, model_coarse, 16, 1'b0);
    repeat (2) tick();
    set_taps(2, '0);
    repeat (2) tick();
    set_taps(2, therm(24, -1));
    repeat (2) tick();
    set_taps(2, '0);
    repeat (4) tick();
    check("ovf_drop", 64'(ovf), 64'(4'b0100));
    check("stall_valid", 64'(out_valid), 64'(1));
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_clear", 64'(ovf), 64'(0));
    out_ready = 1'b1;
    wait_drain("backpressure");
    repeat (2) tick();

    // Disabled detection produces nothing.
    enable = 1'b0;
    rx0    = rx_count;
    set_taps(3, therm(7, -1));
    repeat (4) tick();
    set_taps(3, '0);
    repeat (6) tick();
    check("disabled", 64'(rx_count - rx0), 64'(0));
    enable = 1'b1;

    // Hit sampled right before the coarse counter wraps.
    n = 0;
    while (model_coarse != 16'hFFFF && n < 70000) begin
      tick();
      n++;
    end
    set_taps(0, therm(33, -1));
    push(0, 16'hFFFF, 33, 1'b0);
    repeat (3) tick();
    set_taps(0, '0);
    wait_drain("wrap");

    // Held-high hit fires once.
    rx0 = rx_count;
    set_taps(1, therm(12, -1));
    push(1, model_coarse, 12, 1'b0);
    repeat (50) tick();
    set_taps(1, '0);
    wait_drain("held");
    check("held_once", 64'(rx_count - rx0), 64'(1));
    repeat (2) tick();

    // Reset with a record on the output and two channels pending.
    out_ready = 1'b0;
    set_taps(0, therm(9, -1));
    repeat (2) tick();
    set_taps(0, '0);
    tick();
    set_taps(1, therm(11, -1));
    set_taps(3, therm(13, -1));
    repeat (4) tick();
    check("pre_reset_valid", 64'(out_valid), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check("reset_async", 64'({out_valid, out_channel, out_coarse, out_fine, out_sat, ovf}), 64'(0));
    sb.delete();
    set_taps(1, '0);
    set_taps(3, '0);
    out_ready = 1'b1;
    rx0 = rx_count;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    set_taps(2, therm(17, -1));
    push(2, 16'd5, 17, 1'b0);
    repeat (2) tick();
    set_taps(2, '0);
    wait_drain("post_reset");
    check("post_reset_count", 64'(rx_count - rx0), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
